date_set_controller: RTL

//  User-side writer for the date keeper's overwrite interface. It captures the running date, lets the

---
 rtl/date_pkg.sv | 30 +++
 rtl/date_days_in_month.sv | 38 +++
 rtl/date_set_controller.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/date_pkg.sv
// Shared widths, month constants, FSM states and field_sel encodings for the date setter.
package date_pkg;

  localparam int DAY_W = 5;
  localparam int MON_W = 4;

  localparam logic [MON_W-1:0] JAN = 4'd1;
  localparam logic [MON_W-1:0] FEB = 4'd2;
  localparam logic [MON_W-1:0] APR = 4'd4;
  localparam logic [MON_W-1:0] JUN = 4'd6;
  localparam logic [MON_W-1:0] SEP = 4'd9;
  localparam logic [MON_W-1:0] NOV = 4'd11;
  localparam logic [MON_W-1:0] DEC = 4'd12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_YEAR,
    ST_MONTH,
    ST_DAY,
    ST_COMMIT
  } state_t;

  typedef enum logic [1:0] {
    FS_NONE  = 2'd0,
    FS_DAY   = 2'd1,
    FS_MONTH = 2'd2,
    FS_YEAR  = 2'd3
  } field_t;

endpackage

// File: rtl/date_days_in_month.sv
// Days-in-month lookup. Leap rule is Gregorian when DATE_SET_GREGORIAN_EN is defined,
// otherwise year[1:0]==0 (same rule as the date keeper).
module date_days_in_month
  import date_pkg::*;
#(
  parameter int YEARRES   = 12,
  parameter int YEAR_BASE = 0
) (
  input  logic [MON_W-1:0]   month,
  input  logic [YEARRES-1:0] year,
  output logic [DAY_W-1:0]   dim
);

  logic leap;

`ifdef DATE_SET_GREGORIAN_EN
  logic [31:0] y_abs;

  always_comb begin
    y_abs = 32'(year) + 32'(YEAR_BASE);
    leap  = ((y_abs % 32'd4 == 32'd0) && (y_abs % 32'd100 != 32'd0)) || (y_abs % 32'd400 == 32'd0);
  end
`else
  // Upper year bits and the base offset only matter for the Gregorian rule.
  logic unused_bits;
  assign leap        = (year[1:0] == 2'b00);
  assign unused_bits = ^{year[YEARRES-1:2], YEAR_BASE};
`endif

  always_comb begin
    case (month)
      FEB:                dim = leap ? 5'd29 : 5'd28;
      APR, JUN, SEP, NOV: dim = 5'd30;
      default:            dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/date_set_controller.sv
// Button-driven date editor feeding the date keeper's overwrite port.
// Optional Gregorian leap rule: define DATE_SET_GREGORIAN_EN.
module date_set_controller
  import date_pkg::*;
#(
  parameter int YEARRES     = 12,
  parameter int YEAR_BASE   = 0,
  parameter int TIMEOUT_CYC = 2**26
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_set,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic [YEARRES+8:0] date_cur,
  output logic [YEARRES+8:0] date_set,
  output logic               date_ow,
  output logic               editing,
  output logic [1:0]         field_sel
);

  localparam int                TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [DAY_W-1:0]  DAY_ONE  = DAY_W'(1);

  state_t               state_q, state_d;
  logic [YEARRES-1:0]   year_q, year_d;
  logic [MON_W-1:0]     mon_q, mon_d;
  logic [DAY_W-1:0]     day_q, day_d;
  logic [YEARRES+8:0]   date_set_q, date_set_d;
  logic                 date_ow_q, date_ow_d;
  logic [TW-1:0]        tmo_q, tmo_d;

  logic [DAY_W-1:0]     cur_day;
  logic [MON_W-1:0]     cur_mon;
  logic [YEARRES-1:0]   cur_year;
  logic [DAY_W-1:0]     dim;
  logic                 step_up, step_dn, any_btn, in_edit;

  assign cur_day  = date_cur[YEARRES+MON_W +: DAY_W];
  assign cur_mon  = date_cur[YEARRES +: MON_W];
  assign cur_year = date_cur[YEARRES-1:0];

  assign step_up  = btn_inc & ~btn_dec;
  assign step_dn  = btn_dec & ~btn_inc;
  assign any_btn  = btn_set | btn_inc | btn_dec;
  assign in_edit  = (state_q == ST_YEAR) || (state_q == ST_MONTH) || (state_q == ST_DAY);

  date_days_in_month #(
    .YEARRES  (YEARRES),
    .YEAR_BASE(YEAR_BASE)
  ) u_dim (
    .month(mon_q),
    .year (year_q),
    .dim  (dim)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    year_d     = year_q;
    mon_d      = mon_q;
    day_d      = day_q;
    date_set_d = date_set_q;
    tmo_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (btn_set) begin
          // A day beyond the month length is clamped on DAY entry, always before any commit.
          year_d  = cur_year;
          mon_d   = (cur_mon == '0 || cur_mon > DEC) ? JAN : cur_mon;
          day_d   = (cur_day == '0) ? DAY_ONE : cur_day;
          state_d = ST_YEAR;
        end
      end
      ST_YEAR: begin
        if (btn_set)      state_d = ST_MONTH;
        else if (step_up) year_d  = year_q + 1'b1;
        else if (step_dn) year_d  = year_q - 1'b1;
      end
      ST_MONTH: begin
        if (btn_set) begin
          state_d = ST_DAY;
          if (day_q > dim) day_d = dim;
        end else if (step_up) begin
          mon_d = (mon_q >= DEC) ? JAN : mon_q + 1'b1;
        end else if (step_dn) begin
          mon_d = (mon_q <= JAN) ? DEC : mon_q - 1'b1;
        end
      end
      ST_DAY: begin
        if (btn_set) begin
          // Load the output one cycle ahead of the pulse so it is settled around it.
          state_d    = ST_COMMIT;
          date_set_d = {day_q, mon_q, year_q};
        end else if (step_up) begin
          day_d = (day_q >= dim) ? DAY_ONE : day_q + 1'b1;
        end else if (step_dn) begin
          day_d = (day_q <= DAY_ONE) ? dim : day_q - 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (in_edit && !any_btn) begin
      if (tmo_q == TMO_LAST) begin
        // Abort: restore the edit regs so the idle mirror keeps showing the committed date.
        state_d = ST_IDLE;
        {day_d, mon_d, year_d} = date_set_q;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (state_q == ST_IDLE) date_set_d = {day_q, mon_q, year_q};

    date_ow_d = (state_q == ST_COMMIT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      year_q     <= '0;
      mon_q      <= JAN;
      day_q      <= DAY_ONE;
      date_set_q <= {DAY_ONE, JAN, {YEARRES{1'b0}}};
      date_ow_q  <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      year_q     <= year_d;
      mon_q      <= mon_d;
      day_q      <= day_d;
      date_set_q <= date_set_d;
      date_ow_q  <= date_ow_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_YEAR:  field_sel = FS_YEAR;
      ST_MONTH: field_sel = FS_MONTH;
      ST_DAY:   field_sel = FS_DAY;
      default:  field_sel = FS_NONE;
    endcase
  end

  assign date_set = date_set_q;
  assign date_ow  = date_ow_q;
  assign editing  = (state_q != ST_IDLE);

endmodule
